// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
`timescale 1ns/100ps
package debounce_pkg;

    typedef enum logic {
        STABLE_LOW  = 1'b0,
        STABLE_HIGH = 1'b1
    } db_state_t;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/sync_ff.sv
// N-stage reset-to-0 synchroniser for a single asynchronous level.
`timescale 1ns/100ps
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge input; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Push-button debouncer: synchronises pb_1, filters bounces with a stability
// counter and drives a clean registered level plus one-cycle edge pulses.
`timescale 1ns/100ps
module debouncer
    import debounce_pkg::*;
#(
    parameter int  SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int  STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_1,
    output logic pb_out,
    output logic pb_rise,
    output logic pb_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pb_1),
        .q     (sync_q)
    );

    // The state register is the debounced level itself, so pb_out is a flop.
    assign pb_out  = (state_q == STABLE_HIGH);
    assign pb_rise = rise_q;
    assign pb_fall = fall_q;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (sync_q == pb_out) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Counter stops at CNT_LAST and restarts on the toggle: no wrap.
            state_d = sync_q ? STABLE_HIGH : STABLE_LOW;
            cnt_d   = '0;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Randomised scoreboard bench for the debouncer against a sample-window model.
`timescale 1ns/100ps
module tb_debouncer;

    localparam int SYNC   = 2;
    localparam int STABLE = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic pb_1;
    logic pb_out, pb_rise, pb_fall;

    int n_checks = 0;
    int n_pass   = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    logic [2:0] exp_q[$];

    debouncer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pb_1    (pb_1),
        .pb_out  (pb_out),
        .pb_rise (pb_rise),
        .pb_fall (pb_fall)
    );

    always #1 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference: pb_1 seen SYNC edges late; the level flips once the last
    // STABLE delayed samples all disagree with the current level.
    bit delay_line[$];
    bit window[$];
    bit model_out;

    always @(posedge clk) begin
        bit s, all_diff, r, f;
        if (!rst_n) begin
            delay_line.delete();
            for (int i = 0; i < SYNC; i++) delay_line.push_back(1'b0);
            window.delete();
            model_out = 1'b0;
            exp_q.push_back(3'b000);
        end else begin
            s = delay_line.pop_front();
            delay_line.push_back(pb_1);
            window.push_back(s);
            if (window.size() > STABLE) void'(window.pop_front());
            all_diff = (window.size() == STABLE);
            foreach (window[i]) if (window[i] == model_out) all_diff = 1'b0;
            r = 1'b0;
            f = 1'b0;
            if (all_diff) begin
                model_out = s;
                r = s;
                f = ~s;
            end
            exp_q.push_back({model_out, r, f});
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_out_rise_fall", {29'd0, pb_out, pb_rise, pb_fall}, {29'd0, e});
            if (pb_rise) rise_seen++;
            if (pb_fall) fall_seen++;
        end
    end

    task automatic hold(input logic v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pb_1 = v;
            @(negedge clk);
        end
    endtask

    initial begin
        int r0, f0;
        rst_n = 1'b0;
        pb_1  = 1'b1;

        // Reset held with pb_1 high, then release: rise after SYNC+STABLE.
        repeat (5) @(negedge clk);
        check("reset_out", {31'd0, pb_out}, 32'd0);
        rst_n = 1'b1;
        r0 = rise_seen;
        hold(1'b1, SYNC + STABLE - 1);
        check("out_before_latency", {31'd0, pb_out}, 32'd0);
        hold(1'b1, 1);
        check("out_at_latency", {31'd0, pb_out}, 32'd1);
        hold(1'b1, 10);
        check("reset_release_one_rise", rise_seen - r0, 32'd1);

        // Return low, then short high bursts must be rejected.
        hold(1'b0, 30);
        r0 = rise_seen;
        hold(1'b1, 10); hold(1'b0, 5);
        hold(1'b1, 15); hold(1'b0, 25);
        check("bounce_high_no_rise", rise_seen - r0, 32'd0);
        check("bounce_high_out", {31'd0, pb_out}, 32'd0);

        // Qualified press.
        r0 = rise_seen;
        hold(1'b1, 20);
        check("press_one_rise", rise_seen - r0, 32'd1);

        // Low glitches while high must be rejected.
        f0 = fall_seen;
        for (int i = 0; i < 6; i++) begin
            hold(1'b0, 5);
            hold(1'b1, $urandom_range(20, 10));
        end
        hold(1'b1, 500);
        check("glitch_low_no_fall", fall_seen - f0, 32'd0);
        check("glitch_low_out", {31'd0, pb_out}, 32'd1);

        // Release.
        f0 = fall_seen;
        hold(1'b0, 30);
        check("release_one_fall", fall_seen - f0, 32'd1);

        // Asynchronous reset in the middle of a count with pb_out high.
        hold(1'b1, 25);
        hold(1'b0, 8);
        check("pre_reset_out", {31'd0, pb_out}, 32'd1);
        #0.5;
        rst_n = 1'b0;
        #0.1;
        check("async_reset_out", {31'd0, pb_out}, 32'd0);
        @(negedge clk);
        hold(1'b0, 3);
        rst_n = 1'b1;
        hold(1'b0, 5);

        // Toggle every cycle: pb_out must not move.
        r0 = rise_seen;
        f0 = fall_seen;
        for (int i = 0; i < 100; i++) hold(i[0], 1);
        check("toggle_no_pulses", (rise_seen - r0) + (fall_seen - f0), 32'd0);

        // Random run lengths around the threshold.
        for (int i = 0; i < 80; i++) hold(1'($urandom_range(1, 0)), $urandom_range(40, 1));
        hold(1'b0, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
